// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stall insertion, branch/jump squash and
// saturating stall/flush performance counters for the IF/ID and ID/EX registers.
module hazard_sequencer #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_Jump,
  input  logic             EX_MemtoReg,
  input  logic             EX_RegWr,
  input  logic [4:0]       EX_wr_reg,
  input  logic             EX_BranchTaken,
  input  logic             cnt_clr,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             seq_state
);

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  localparam logic [1:0] LU_RELOAD = 2'(LU_STALL_CYCLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       down_cnt, down_cnt_nxt;
  logic             load_use;
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // $zero is never a real dependency, so a zero destination cannot stall.
  assign load_use = EX_MemtoReg && EX_RegWr && (EX_wr_reg != 5'd0) &&
                    ((ID_UseRs && (ID_rs == EX_wr_reg)) ||
                     (ID_UseRt && (ID_rt == EX_wr_reg)));

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    state_nxt    = state;
    down_cnt_nxt = down_cnt;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (!reset) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      state_nxt    = RUN;
      down_cnt_nxt = 2'd0;
    end else if (EX_BranchTaken) begin
      // The ID instruction is wrong-path, so the squash beats any stall or jump.
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      flush_inc    = 1'b1;
      state_nxt    = RUN;
      down_cnt_nxt = 2'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (load_use) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            stall_inc   = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              state_nxt    = LU_STALL;
              down_cnt_nxt = LU_RELOAD;
            end
          end else if (ID_Jump) begin
            IF_ID_flush = 1'b1;
            flush_inc   = 1'b1;
          end
        end
        LU_STALL: begin
          PC_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_flush  = 1'b1;
          stall_inc    = 1'b1;
          down_cnt_nxt = down_cnt - 2'd1;
          if (down_cnt == 2'd1) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      down_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      down_cnt <= down_cnt_nxt;
    end
  end

  // Counters hold at all-ones; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!reset || cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign seq_state = (state == LU_STALL);

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: three instances (LU=1, LU=3, LU=2 with
// 4-bit counters) share stimulus and are compared every cycle against a behavioural model.
module tb_hazard_sequencer;

  logic       clk;
  logic       reset;
  logic [4:0] ID_rs, ID_rt, EX_wr_reg;
  logic       ID_UseRs, ID_UseRt, ID_Jump;
  logic       EX_MemtoReg, EX_RegWr, EX_BranchTaken, cnt_clr;

  logic        pcw0, ifw0, iff0, exf0, seq0;
  logic        pcw1, ifw1, iff1, exf1, seq1;
  logic        pcw2, ifw2, iff2, exf2, seq2;
  logic [31:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_sequencer #(.LU_STALL_CYCLES(1), .CNT_W(32)) u_lu1 (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs),
    .ID_UseRt(ID_UseRt), .ID_Jump(ID_Jump), .EX_MemtoReg(EX_MemtoReg), .EX_RegWr(EX_RegWr),
    .EX_wr_reg(EX_wr_reg), .EX_BranchTaken(EX_BranchTaken), .cnt_clr(cnt_clr),
    .PC_write(pcw0), .IF_ID_write(ifw0), .IF_ID_flush(iff0), .ID_EX_flush(exf0),
    .stall_cnt(sc0), .flush_cnt(fc0), .seq_state(seq0));

  hazard_sequencer #(.LU_STALL_CYCLES(3), .CNT_W(32)) u_lu3 (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs),
    .ID_UseRt(ID_UseRt), .ID_Jump(ID_Jump), .EX_MemtoReg(EX_MemtoReg), .EX_RegWr(EX_RegWr),
    .EX_wr_reg(EX_wr_reg), .EX_BranchTaken(EX_BranchTaken), .cnt_clr(cnt_clr),
    .PC_write(pcw1), .IF_ID_write(ifw1), .IF_ID_flush(iff1), .ID_EX_flush(exf1),
    .stall_cnt(sc1), .flush_cnt(fc1), .seq_state(seq1));

  hazard_sequencer #(.LU_STALL_CYCLES(2), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRs(ID_UseRs),
    .ID_UseRt(ID_UseRt), .ID_Jump(ID_Jump), .EX_MemtoReg(EX_MemtoReg), .EX_RegWr(EX_RegWr),
    .EX_wr_reg(EX_wr_reg), .EX_BranchTaken(EX_BranchTaken), .cnt_clr(cnt_clr),
    .PC_write(pcw2), .IF_ID_write(ifw2), .IF_ID_flush(iff2), .ID_EX_flush(exf2),
    .stall_cnt(sc2), .flush_cnt(fc2), .seq_state(seq2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // rem = stall cycles still owed after the current one; counters are plain integers.
  int     lu_cyc[3] = '{1, 3, 2};
  longint maxc[3]   = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  int     rem[3]    = '{0, 0, 0};
  longint msc[3]    = '{0, 0, 0};
  longint mfc[3]    = '{0, 0, 0};

  logic [3:0]  ctl[3];
  logic        st[3];
  logic [31:0] scv[3], fcv[3];

  always_comb begin
    ctl[0] = {pcw0, ifw0, iff0, exf0};
    ctl[1] = {pcw1, ifw1, iff1, exf1};
    ctl[2] = {pcw2, ifw2, iff2, exf2};
    st[0]  = seq0;
    st[1]  = seq1;
    st[2]  = seq2;
    scv[0] = sc0;
    scv[1] = sc1;
    scv[2] = {28'd0, sc2};
    fcv[0] = fc0;
    fcv[1] = fc1;
    fcv[2] = {28'd0, fc2};
  end

  always @(negedge clk) begin
    logic       hz, stall_now, flush_now;
    logic [3:0] exp_c;
    hz = EX_MemtoReg && EX_RegWr && (EX_wr_reg != 5'd0) &&
         ((ID_UseRs && ID_rs == EX_wr_reg) || (ID_UseRt && ID_rt == EX_wr_reg));
    for (int i = 0; i < 3; i++) begin
      stall_now = 1'b0;
      flush_now = 1'b0;
      if (!reset)                     exp_c = 4'b0011;
      else if (EX_BranchTaken)        begin exp_c = 4'b1111; flush_now = 1'b1; end
      else if (rem[i] > 0 || hz)      begin exp_c = 4'b0001; stall_now = 1'b1; end
      else if (ID_Jump)               begin exp_c = 4'b1110; flush_now = 1'b1; end
      else                            exp_c = 4'b1100;

      check($sformatf("ctl[%0d] t=%0t", i, $time), ctl[i], exp_c);
      check($sformatf("seq[%0d] t=%0t", i, $time), st[i], rem[i] > 0);
      check($sformatf("stall_cnt[%0d] t=%0t", i, $time), scv[i], msc[i]);
      check($sformatf("flush_cnt[%0d] t=%0t", i, $time), fcv[i], mfc[i]);

      if (!reset) begin
        rem[i] = 0; msc[i] = 0; mfc[i] = 0;
      end else begin
        if (EX_BranchTaken)    rem[i] = 0;
        else if (rem[i] > 0)   rem[i] = rem[i] - 1;
        else if (hz)           rem[i] = lu_cyc[i] - 1;
        if (cnt_clr) begin
          msc[i] = 0; mfc[i] = 0;
        end else begin
          if (stall_now && msc[i] < maxc[i]) msc[i]++;
          if (flush_now && mfc[i] < maxc[i]) mfc[i]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    reset = 1'b1; ID_rs = 5'd0; ID_rt = 5'd0; ID_UseRs = 1'b0; ID_UseRt = 1'b0;
    ID_Jump = 1'b0; EX_MemtoReg = 1'b0; EX_RegWr = 1'b0; EX_wr_reg = 5'd0;
    EX_BranchTaken = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic hazard(input logic [4:0] r);
    EX_MemtoReg = 1'b1; EX_RegWr = 1'b1; EX_wr_reg = r; ID_rs = r; ID_UseRs = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    step(); step();
    @(negedge clk);
    check("reset PC_write", pcw0, 1'b0);
    check("reset IF_ID_write", ifw0, 1'b0);
    check("reset flushes", {iff1, exf1}, 2'b11);
    step();

    // reset release: normal RUN, counters zero
    idle();
    @(negedge clk);
    check("post-reset PC_write", pcw0, 1'b1);
    check("post-reset seq", seq1, 1'b0);
    check("post-reset stall_cnt", sc0, 32'd0);
    check("post-reset flush_cnt", fc0, 32'd0);
    step();

    // lw $8 in EX, add reading $8 in ID, for one cycle
    hazard(5'd8);
    @(negedge clk);
    check("lu1 stall ctl", {pcw0, ifw0, iff0, exf0}, 4'b0001);
    step();
    idle();
    @(negedge clk);
    check("lu1 resumes", pcw0, 1'b1);
    check("lu3 stall2", {pcw1, seq1}, 2'b01);
    step();
    @(negedge clk);
    check("lu3 stall3", {pcw1, seq1}, 2'b01);
    check("lu2 resumes", pcw2, 1'b1);
    step();
    @(negedge clk);
    check("lu3 resumes", {pcw1, seq1}, 2'b10);
    check("lu1 stall_cnt", sc0, 32'd1);
    check("lu3 stall_cnt", sc1, 32'd3);
    check("lu2 stall_cnt", sc2, 4'd2);
    step();

    // $zero destination never stalls
    EX_MemtoReg = 1'b1; EX_RegWr = 1'b1; EX_wr_reg = 5'd0;
    ID_UseRs = 1'b1; ID_UseRt = 1'b1;
    @(negedge clk);
    check("zero reg no stall", {pcw0, pcw1, pcw2}, 3'b111);
    step();
    // non-load writer and unused-operand match: no stall
    idle(); EX_RegWr = 1'b1; EX_wr_reg = 5'd8; ID_rs = 5'd8; ID_UseRs = 1'b1;
    step();
    idle(); hazard(5'd9); ID_UseRs = 1'b0;
    step();
    // rt-path hazard
    idle(); EX_MemtoReg = 1'b1; EX_RegWr = 1'b1; EX_wr_reg = 5'd5; ID_rt = 5'd5; ID_UseRt = 1'b1;
    step();
    idle();
    for (int i = 0; i < 3; i++) step();

    // branch coincident with load-use and jump
    cnt_clr = 1'b1;
    step();
    idle(); hazard(5'd8); ID_Jump = 1'b1; EX_BranchTaken = 1'b1;
    @(negedge clk);
    check("branch ctl", {pcw0, ifw0, iff0, exf0}, 4'b1111);
    step();
    idle();
    @(negedge clk);
    check("branch stall_cnt", sc0, 32'd0);
    check("branch flush_cnt", fc0, 32'd1);
    step();

    // jump alone, then clear with a simultaneous jump
    cnt_clr = 1'b1;
    step();
    idle(); ID_Jump = 1'b1;
    @(negedge clk);
    check("jump ctl", {pcw0, iff0, exf0}, 3'b110);
    step();
    cnt_clr = 1'b1;
    @(negedge clk);
    check("jump flush_cnt", fc0, 32'd1);
    step();
    idle();
    @(negedge clk);
    check("clr beats jump", fc0, 32'd0);
    step();

    // branch while LU=3 instance is stalling
    hazard(5'd3);
    step();
    idle(); EX_BranchTaken = 1'b1;
    @(negedge clk);
    check("branch in stall ctl", {pcw1, iff1, exf1}, 3'b111);
    step();
    idle();
    @(negedge clk);
    check("branch in stall exits", {pcw1, seq1}, 2'b10);
    step();

    // saturation: hazard held for 20 cycles
    cnt_clr = 1'b1;
    step();
    idle(); hazard(5'd12);
    for (int i = 0; i < 20; i++) step();
    idle();
    @(negedge clk);
    check("sat stall_cnt", sc2, 4'd15);
    check("lu1 20 stalls", sc0, 32'd20);
    check("lu3 20 stalls", sc1, 32'd20);
    step();
    for (int i = 0; i < 3; i++) step();

    // reset in the middle of an LU_STALL
    hazard(5'd7);
    step();
    idle(); reset = 1'b0;
    @(negedge clk);
    check("in stall before reset", seq1, 1'b1);
    step();
    idle();
    @(negedge clk);
    check("reset aborts stall", {pcw1, seq1}, 2'b10);
    check("reset clears stall_cnt", sc1, 32'd0);
    check("reset clears sat cnt", sc2, 4'd0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control block that sequences the IF/ID and ID/EX pipeline registers.
- Detects load-use hazards and holds PC and IF/ID for a programmable number of cycles. During the hold it injects bubbles into ID/EX through its flush input.
- Squashes wrong-path instructions on a taken branch resolved in EX and on a jump decoded in ID.
- Keeps saturating stall and flush performance counters for bring-up and CPI measurement.

Parameters:
LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..3
CNT_W, 32, width of the performance counters

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
ID_rs  input  5  rs field of the instruction in ID
ID_rt  input  5  rt field of the instruction in ID
ID_UseRs  input  1  ID instruction reads rs
ID_UseRt  input  1  ID instruction reads rt
ID_Jump  input  1  ID instruction is a jump (j/jal/jr)
EX_MemtoReg  input  1  EX instruction is a load
EX_RegWr  input  1  EX instruction writes the register file
EX_wr_reg  input  5  destination register of the EX instruction, after RegDst selection
EX_BranchTaken  input  1  branch in EX resolved as taken
cnt_clr  input  1  synchronous clear of both performance counters
PC_write  output  1  PC update enable
IF_ID_write  output  1  IF/ID register load enable
IF_ID_flush  output  1  zero the IF/ID register on the next edge
ID_EX_flush  output  1  zero the ID/EX register on the next edge (inserts a bubble)
stall_cnt  output  CNT_W  count of cycles with PC_write=0 outside reset
flush_cnt  output  CNT_W  count of branch/jump squash events
seq_state  output  1  FSM state, 0=RUN, 1=LU_STALL (debug)

Behaviour:
- Hazard term: load_use = EX_MemtoReg & EX_RegWr & (EX_wr_reg!=0) & ((ID_UseRs & ID_rs==EX_wr_reg) | (ID_UseRt & ID_rt==EX_wr_reg)).
- Control outputs are combinational from state and inputs, with zero-cycle latency. Counters, FSM state and the stall down-counter are registered.
- While reset=0:
  - PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1.
  - On the edge: state<=RUN, down-counter<=0, stall_cnt<=0, flush_cnt<=0.
  - Counters do not count reset cycles.
- RUN, priority order:
  1. EX_BranchTaken=1: PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_flush=1; flush_cnt+1; stay RUN. Overrides load_use and ID_Jump, because the ID instruction is wrong-path.
  2. load_use=1: PC_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0; stall_cnt+1.
     - If LU_STALL_CYCLES==1, stay RUN.
     - Otherwise go to LU_STALL with down-counter<=LU_STALL_CYCLES-1.
  3. ID_Jump=1: PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_flush=0; flush_cnt+1.
  4. Otherwise: PC_write=1, IF_ID_write=1, both flushes 0.
- LU_STALL:
  - PC_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0; stall_cnt+1; down-counter-1.
  - Return to RUN on the edge where the down-counter equals 1.
  - Total stall is exactly LU_STALL_CYCLES cycles per hazard.
  - ID_Jump and load_use are ignored in this state. They are re-evaluated in RUN with the same ID instruction.
  - EX_BranchTaken=1 cannot occur here (EX holds a bubble). If it is asserted, treat it as in RUN priority 1: flush, return to RUN, clear the down-counter.
- Counters:
  - Saturate at all-ones and never wrap.
  - cnt_clr=1 loads 0 to both counters and wins over a same-cycle increment.
  - Reset wins over cnt_clr.
- Reset mid-stall: aborts to RUN on the edge; the first cycle after reset release is a normal RUN cycle.
- EX_wr_reg==0 never causes a stall, because $zero is not a dependency.

Test Plan:
- Reset low for 2 cycles, then high: during reset PC_write=0, IF_ID_write=0, both flushes=1. After release seq_state=0, stall_cnt=0, flush_cnt=0, PC_write=1.
- LU_STALL_CYCLES=1; EX lw to $8, ID add reading rs=$8 -> one cycle with PC_write=0, IF_ID_write=0, ID_EX_flush=1; next cycle normal; stall_cnt=1.
- LU_STALL_CYCLES=3, same hazard -> exactly 3 stalled cycles, seq_state=1 for cycles 2-3, stall_cnt=3. EX_wr_reg=0 with matching ID_rs=0 -> no stall.
- EX_BranchTaken=1 coincident with load_use and ID_Jump -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1; stall_cnt unchanged; flush_cnt+1.
- ID_Jump alone for 1 cycle -> IF_ID_flush=1, ID_EX_flush=0; flush_cnt=1. Then cnt_clr with a simultaneous jump -> flush_cnt=0.
- CNT_W=4: drive 20 load-use hazards -> stall_cnt saturates at 15. Assert reset during LU_STALL -> state RUN and counters 0 on the next edge.
